score_display_mux: RTL and testbench

//  Time-multiplexed 4-digit seven-segment driver for the Basys3 score display.

---
 rtl/score_display_mux_pkg.sv | 40 ++++
 rtl/score_display_mux_if.sv | 26 ++
 rtl/score_display_mux_bcd_to_7seg.sv | 27 ++
 rtl/score_display_mux.sv | 124 ++++++++++++
 tb/tb_score_display_mux.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/score_display_mux_pkg.sv
// Shared constants and types for the four-digit score display driver.
package score_display_mux_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned BCD_W      = 4;

  // Anodes are active-low; AN_MSB marks the leftmost digit before inversion.
  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{1'b1}};
  localparam logic [NUM_DIGITS-1:0] AN_MSB = {1'b1, {(NUM_DIGITS-1){1'b0}}};

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [SEG_W-1:0] SEG_0    = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1    = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2    = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3    = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4    = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5    = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6    = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7    = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8    = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9    = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_DASH = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_OFF  = 7'b1111111;

  // Frame snapshot of the score digits and blanking mode.
  typedef struct packed {
    logic [BCD_W-1:0] bcd1_l;
    logic [BCD_W-1:0] bcd0_l;
    logic [BCD_W-1:0] bcd1_r;
    logic [BCD_W-1:0] bcd0_r;
    logic             blank_lead;
  } digits_t;

  // Counter width for a modulus, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/score_display_mux_if.sv
// Score inputs and seven-segment pins between the score logic and the display driver.
interface score_display_mux_if;
  import score_display_mux_pkg::*;

  logic [BCD_W-1:0]      bcd1_l;
  logic [BCD_W-1:0]      bcd0_l;
  logic [BCD_W-1:0]      bcd1_r;
  logic [BCD_W-1:0]      bcd0_r;
  logic                  blank_lead;
  logic                  blink_l;
  logic                  blink_r;
  logic [NUM_DIGITS-1:0] an;
  logic [SEG_W-1:0]      seg;
  logic                  dp;

  modport master (
    output bcd1_l, bcd0_l, bcd1_r, bcd0_r, blank_lead, blink_l, blink_r,
    input  an, seg, dp
  );

  modport slave (
    input  bcd1_l, bcd0_l, bcd1_r, bcd0_r, blank_lead, blink_l, blink_r,
    output an, seg, dp
  );

endinterface

// File: rtl/score_display_mux_bcd_to_7seg.sv
// Combinational BCD to active-low seven-segment decoder; non-decimal codes show a dash.
module bcd_to_7seg
  import score_display_mux_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_i,
  output logic [SEG_W-1:0] seg_o_c
);

  // Pattern lookup.
  always_comb begin
    seg_o_c = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o_c = SEG_0;
      4'd1:    seg_o_c = SEG_1;
      4'd2:    seg_o_c = SEG_2;
      4'd3:    seg_o_c = SEG_3;
      4'd4:    seg_o_c = SEG_4;
      4'd5:    seg_o_c = SEG_5;
      4'd6:    seg_o_c = SEG_6;
      4'd7:    seg_o_c = SEG_7;
      4'd8:    seg_o_c = SEG_8;
      4'd9:    seg_o_c = SEG_9;
      default: seg_o_c = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/score_display_mux.sv
// Time-multiplexed 4-digit score display: anode scan, guard band, tear-free
// frame snapshot, leading-zero blanking and winner blink, registered pins.
module score_display_mux
  import score_display_mux_pkg::*;
#(
  parameter int unsigned DIGIT_TICKS  = 65000,
  parameter int unsigned GUARD_TICKS  = 650,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input  logic         clk,
  input  logic         rst_n,
  score_display_mux_if.slave disp
);

  localparam int unsigned TICK_W  = cnt_w(DIGIT_TICKS);
  localparam int unsigned FRAME_W = cnt_w(BLINK_FRAMES);
  localparam int unsigned SLOT_W  = cnt_w(NUM_DIGITS);

  localparam logic [TICK_W-1:0]  TICK_MAX  = TICK_W'(DIGIT_TICKS - 1);
  localparam logic [TICK_W-1:0]  GUARD_END = TICK_W'(GUARD_TICKS);
  localparam logic [FRAME_W-1:0] FRAME_MAX = FRAME_W'(BLINK_FRAMES - 1);
  localparam logic [SLOT_W-1:0]  SLOT_MAX  = SLOT_W'(NUM_DIGITS - 1);

  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [FRAME_W-1:0]    frame_q, frame_d;
  logic                  hidden_q, hidden_d;
  digits_t               shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic                  tick_wrap_c;
  logic                  frame_start_c;
  logic                  guard_c;
  logic                  tens_c;
  logic                  left_c;
  logic                  blank_c;
  logic [BCD_W-1:0]      digit_c;
  logic [SEG_W-1:0]      seg_dec_c;

  bcd_to_7seg u_dec (
    .bcd_i   (digit_c),
    .seg_o_c (seg_dec_c)
  );

  // Scan timing, frame snapshot and blink phase next-state.
  always_comb begin
    tick_wrap_c   = (tick_q == TICK_MAX);
    frame_start_c = tick_wrap_c && (slot_q == SLOT_MAX);
    tick_d        = tick_wrap_c ? '0 : tick_q + TICK_W'(1);
    slot_d        = slot_q;
    frame_d       = frame_q;
    hidden_d      = hidden_q;
    shadow_d      = shadow_q;
    if (tick_wrap_c) begin
      slot_d = (slot_q == SLOT_MAX) ? '0 : slot_q + SLOT_W'(1);
    end
    if (frame_start_c) begin
      shadow_d = '{bcd1_l:     disp.bcd1_l,
                   bcd0_l:     disp.bcd0_l,
                   bcd1_r:     disp.bcd1_r,
                   bcd0_r:     disp.bcd0_r,
                   blank_lead: disp.blank_lead};
      if (frame_q == FRAME_MAX) begin
        frame_d  = '0;
        hidden_d = ~hidden_q;
      end else begin
        frame_d = frame_q + FRAME_W'(1);
      end
    end
  end

  // Pin values for the current slot and tick, registered below.
  always_comb begin
    case (slot_q)
      2'd0:    digit_c = shadow_q.bcd1_l;
      2'd1:    digit_c = shadow_q.bcd0_l;
      2'd2:    digit_c = shadow_q.bcd1_r;
      default: digit_c = shadow_q.bcd0_r;
    endcase
    guard_c = (tick_q < GUARD_END);
    tens_c  = ~slot_q[0];
    left_c  = ~slot_q[1];
    blank_c = (tens_c && (digit_c == '0) && shadow_q.blank_lead) ||
              (hidden_q && (left_c ? disp.blink_l : disp.blink_r));
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (!guard_c) begin
      an_d  = ~(AN_MSB >> slot_q);
      seg_d = blank_c ? SEG_OFF : seg_dec_c;
      dp_d  = (slot_q != SLOT_W'(1));
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q   <= '0;
      slot_q   <= '0;
      frame_q  <= '0;
      hidden_q <= 1'b0;
      shadow_q <= '0;
      an_q     <= AN_OFF;
      seg_q    <= SEG_OFF;
      dp_q     <= 1'b1;
    end else begin
      tick_q   <= tick_d;
      slot_q   <= slot_d;
      frame_q  <= frame_d;
      hidden_q <= hidden_d;
      shadow_q <= shadow_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign disp.an  = an_q;
  assign disp.seg = seg_q;
  assign disp.dp  = dp_q;

endmodule

// File: tb/tb_score_display_mux.sv
// Directed bench for score_display_mux with shortened timing parameters.
module tb_score_display_mux;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   fr;

  score_display_mux_if disp_if ();

  score_display_mux #(
    .DIGIT_TICKS  (4),
    .GUARD_TICKS  (1),
    .BLINK_FRAMES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .disp  (disp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value.
  task automatic check_eq(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One 4-cycle digit slot: guard cycle, then three lit cycles.
  task automatic check_slot(input int s, input logic [6:0] exp_seg);
    logic [3:0] an_lit;
    logic [3:0] a;
    logic [6:0] sg;
    logic       d;
    an_lit = 4'b1000;
    an_lit = ~(an_lit >> s);
    for (int k = 0; k < 4; k++) begin
      step();
      a  = (k == 0) ? 4'b1111 : an_lit;
      sg = (k == 0) ? 7'h7F : exp_seg;
      d  = (s == 1 && k != 0) ? 1'b0 : 1'b1;
      check_eq($sformatf("f%0d s%0d t%0d an", fr, s, k), 7'(disp_if.an), 7'(a));
      check_eq($sformatf("f%0d s%0d t%0d seg", fr, s, k), disp_if.seg, sg);
      check_eq($sformatf("f%0d s%0d t%0d dp", fr, s, k), 7'(disp_if.dp), 7'(d));
    end
  endtask

  task automatic check_frame(input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3);
    check_slot(0, s0);
    check_slot(1, s1);
    check_slot(2, s2);
    check_slot(3, s3);
    fr++;
  endtask

  task automatic check_reset_pins(input string tag);
    check_eq({tag, " an"}, 7'(disp_if.an), 7'h0F);
    check_eq({tag, " seg"}, disp_if.seg, 7'h7F);
    check_eq({tag, " dp"}, 7'(disp_if.dp), 7'h01);
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    fr       = 0;
    rst_n    = 1'b0;
    disp_if.bcd1_l     = 4'd1;
    disp_if.bcd0_l     = 4'd2;
    disp_if.bcd1_r     = 4'd3;
    disp_if.bcd0_r     = 4'd4;
    disp_if.blank_lead = 1'b0;
    disp_if.blink_l    = 1'b0;
    disp_if.blink_r    = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_pins("reset");
    rst_n = 1'b1;

    // Frame 0 shows the zeroed snapshot.
    check_frame(7'h40, 7'h40, 7'h40, 7'h40);

    // Frame 1: live digits; change bcd0_r mid-frame, must not tear.
    check_slot(0, 7'h79);
    check_slot(1, 7'h24);
    disp_if.bcd0_r = 4'd7;
    check_slot(2, 7'h30);
    check_slot(3, 7'h19);
    fr++;

    disp_if.bcd1_l     = 4'd0;
    disp_if.blank_lead = 1'b1;
    check_frame(7'h79, 7'h24, 7'h30, 7'h78);

    disp_if.blank_lead = 1'b0;
    disp_if.bcd1_r     = 4'hC;
    check_frame(7'h7F, 7'h24, 7'h30, 7'h78);

    check_frame(7'h40, 7'h24, 7'h3F, 7'h78);

    // Blink on the left player: frames 6,7 hidden; 5,8,9 visible.
    disp_if.blink_l = 1'b1;
    check_frame(7'h40, 7'h24, 7'h3F, 7'h78);
    check_frame(7'h7F, 7'h7F, 7'h3F, 7'h78);
    check_frame(7'h7F, 7'h7F, 7'h3F, 7'h78);
    check_frame(7'h40, 7'h24, 7'h3F, 7'h78);
    check_frame(7'h40, 7'h24, 7'h3F, 7'h78);

    // Frame 10 (hidden): reset in the middle of slot 1.
    check_slot(0, 7'h7F);
    step();
    step();
    check_eq("mid an", 7'(disp_if.an), 7'h0B);
    check_eq("mid seg", disp_if.seg, 7'h7F);
    check_eq("mid dp", 7'(disp_if.dp), 7'h00);
    rst_n = 1'b0;
    #1;
    check_reset_pins("midreset");
    repeat (2) @(negedge clk);
    check_reset_pins("midreset hold");
    rst_n = 1'b1;
    fr    = 0;

    // Snapshot and blink phase restart from reset values.
    check_frame(7'h40, 7'h40, 7'h40, 7'h40);
    check_frame(7'h40, 7'h24, 7'h3F, 7'h78);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
